// File: rtl/thee_freq_counter.sv
// ---------------------------------------------------------------------------
// thee_freq_counter
//
// Frequency meter. Counts rising edges of an asynchronous input over a fixed
// gate window of GATE_CYCLES clk cycles and reports the count, so that
//   f_sig = cnt_out * f_clk / GATE_CYCLES
// Meaningful only while f_sig <= f_clk/2.
//
// Parameters
//   GATE_CYCLES  gate window length in clk cycles (>= 1)
//   CNT_W        width of the edge counter and of cnt_out
//   SYNC_STAGES  synchronizer depth on sig_in (>= 2)
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   start       one-cycle measurement request, honoured only while idle
//   continuous  level; 1 re-arms a new window straight after each result
//   sig_in      asynchronous signal being measured
//   busy        1 while a measurement is armed, gating or finishing
//   cnt_valid   one-cycle pulse when cnt_out/overflow are updated
//   cnt_out     rising-edge count of the last completed window
//   overflow    last window saturated the counter (held alongside cnt_out)
//
// Build option
//   FREQ_COUNTER_GLITCH_FILT_EN
//     defined   : a filter register between the synchronizer and the edge
//                 detector rejects pulses shorter than two clk cycles; the
//                 edge latency grows by one cycle.
//     undefined : the edge detector looks at the synchronizer output directly.
//
// Timing from the cycle in which start is sampled:
//   ARM (1 cycle) -> GATE (GATE_CYCLES cycles) -> DONE (1 cycle, cnt_valid=1)
// so cnt_valid appears GATE_CYCLES+2 cycles later, and continuous windows
// repeat with the same period. Rises during ARM or DONE are not counted.
// ---------------------------------------------------------------------------
module thee_freq_counter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             sig_in,
  output logic             busy,
  output logic             cnt_valid,
  output logic [CNT_W-1:0] cnt_out,
  output logic             overflow
);

  // Gate counter is wide enough to hold GATE_CYCLES itself.
  localparam int                GATE_W    = $clog2(GATE_CYCLES + 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [SYNC_STAGES-1:0] sync;
  logic               s;
  logic               det_in;
  logic               s_d;
  logic               rise;
  logic [GATE_W-1:0]  gate_ctr;
  logic [CNT_W-1:0]   edge_ctr;
  logic [CNT_W-1:0]   edge_nxt;
  logic               ovf_flag;
  logic               ovf_nxt;

  // Synchronizer: sync[0] is the newest sample, s the oldest (fully settled).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign s = sync[SYNC_STAGES-1];

`ifdef FREQ_COUNTER_GLITCH_FILT_EN
  // Glitch filter: follow s only when it agrees with the sample behind it,
  // so a level must persist for two clk cycles before it is passed on.
  logic filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= 1'b0;
    end else if (s == sync[SYNC_STAGES-2]) begin
      filt <= s;
    end
  end

  assign det_in = filt;
`else
  assign det_in = s;
`endif

  // Edge detector delay register; a rise is a 0->1 step of the detector input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d <= 1'b0;
    end else begin
      s_d <= det_in;
    end
  end

  assign rise = det_in & ~s_d;

  // Saturating next-count: once the counter is pinned at its maximum, further
  // rises only raise the overflow flag.
  always_comb begin
    edge_nxt = edge_ctr;
    ovf_nxt  = ovf_flag;
    if (rise) begin
      if (edge_ctr == CNT_MAX) begin
        ovf_nxt = 1'b1;
      end else begin
        edge_nxt = edge_ctr + CNT_W'(1);
      end
    end
  end

  // Measurement FSM with registered outputs. The result is captured on the
  // last GATE cycle using the next-count values, so a rise in that final
  // cycle still makes it into cnt_out, and cnt_valid lines up with DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gate_ctr  <= '0;
      edge_ctr  <= '0;
      ovf_flag  <= 1'b0;
      cnt_out   <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end

        ARM: begin
          gate_ctr <= '0;
          edge_ctr <= '0;
          ovf_flag <= 1'b0;
          state    <= GATE;
        end

        GATE: begin
          edge_ctr <= edge_nxt;
          ovf_flag <= ovf_nxt;
          if (gate_ctr == GATE_LAST) begin
            state     <= DONE;
            cnt_out   <= edge_nxt;
            overflow  <= ovf_nxt;
            cnt_valid <= 1'b1;
          end else begin
            gate_ctr <= gate_ctr + GATE_W'(1);
          end
        end

        DONE: begin
          if (continuous) begin
            state <= ARM;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
